// File: rtl/wbarb_pkg.sv
// rtl/wbarb_pkg.sv - shared constants, types and helpers for the writeback arbiter
package wbarb_pkg;

  // Datapath widths of the writeback bus
  localparam int XLEN     = 32;
  localparam int ROBID_W  = 7;
  localparam int RD_W     = 6;
  localparam int ECAUSE_W = 5;

  // Producer indices into the request / grant vectors
  localparam int NSRC = 3;
  localparam logic [1:0] SRC_SCALU  = 2'd0;
  localparam logic [1:0] SRC_LSQ    = 2'd1;
  localparam logic [1:0] SRC_MULDIV = 2'd2;

  // Exception cause encodings carried on the *_ecause fields
  typedef enum logic [ECAUSE_W-1:0] {
    EC_NONE          = 5'd0,
    EC_ILLEGAL_INSN  = 5'd2,
    EC_BREAKPOINT    = 5'd3,
    EC_LD_MISALIGN   = 5'd4,
    EC_LD_FAULT      = 5'd5,
    EC_ST_MISALIGN   = 5'd6,
    EC_ST_FAULT      = 5'd7,
    EC_DIV_ZERO      = 5'd24
  } ecause_e;

  // One producer's result as it travels to the writeback bus
  typedef struct packed {
    logic                error;
    logic [ECAUSE_W-1:0] ecause;
    logic [ROBID_W-1:0]  robid;
    logic [RD_W-1:0]     rd;
    logic [XLEN-1:0]     result;
  } wb_payload_t;

  localparam int PAYLOAD_W = $bits(wb_payload_t);

  // Number of producers requesting in a 3-bit request vector
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Index of the set bit in a one-hot 3-bit vector (0 when none is set)
  function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/wbarb_rr_arb3.sv
// rtl/wbarb_rr_arb3.sv - three-way round-robin arbiter with last-grant pointer
module rr_arb3
  import wbarb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] grant
);

  // Index of the most recently granted requester; reset to muldiv so
  // that scalu holds top priority out of reset.
  logic [1:0] last_q;

  // Grant the first requester found starting just after the last winner
  always_comb begin
    grant = 3'b000;
    if (en) begin
      unique case (last_q)
        SRC_SCALU: begin
          if (req[1])      grant = 3'b010;
          else if (req[2]) grant = 3'b100;
          else if (req[0]) grant = 3'b001;
        end
        SRC_LSQ: begin
          if (req[2])      grant = 3'b100;
          else if (req[0]) grant = 3'b001;
          else if (req[1]) grant = 3'b010;
        end
        default: begin
          if (req[0])      grant = 3'b001;
          else if (req[1]) grant = 3'b010;
          else if (req[2]) grant = 3'b100;
        end
      endcase
    end
  end

  // Pointer moves to the winner only on cycles that actually grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= SRC_MULDIV;
    end else if (|grant) begin
      last_q <= onehot3_to_idx(grant);
    end
  end

endmodule

// File: rtl/wbarb.sv
// rtl/wbarb.sv - round-robin writeback arbiter for scalu, lsq and muldiv results
module wbarb
  import wbarb_pkg::*;
#(
  // Reset value of the contention counter; 0 in normal use
  parameter logic [31:0] CONFLICT_INIT = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  // single-cycle ALU
  input  logic                scalu_valid,
  input  logic                scalu_error,
  input  logic [ECAUSE_W-1:0] scalu_ecause,
  input  logic [ROBID_W-1:0]  scalu_robid,
  input  logic [RD_W-1:0]     scalu_rd,
  input  logic [XLEN-1:0]     scalu_result,
  // load/store queue
  input  logic                lsq_valid,
  input  logic                lsq_error,
  input  logic [ECAUSE_W-1:0] lsq_ecause,
  input  logic [ROBID_W-1:0]  lsq_robid,
  input  logic [RD_W-1:0]     lsq_rd,
  input  logic [XLEN-1:0]     lsq_result,
  // mul/div unit
  input  logic                muldiv_valid,
  input  logic                muldiv_error,
  input  logic [ECAUSE_W-1:0] muldiv_ecause,
  input  logic [ROBID_W-1:0]  muldiv_robid,
  input  logic [RD_W-1:0]     muldiv_rd,
  input  logic [XLEN-1:0]     muldiv_result,
  // back-pressure to producers
  output logic                wb_scalu_stall,
  output logic                wb_lsq_stall,
  output logic                wb_muldiv_stall,
  // writeback bus
  output logic                wb_valid,
  output logic                wb_error,
  output logic [ECAUSE_W-1:0] wb_ecause,
  output logic [ROBID_W-1:0]  wb_robid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [XLEN-1:0]     wb_result,
  output logic                wb_regwr,
  output logic [31:0]         wb_conflicts,
  input  logic                rob_flush
);

  logic [2:0]           req;
  logic [2:0]           grant;
  wb_payload_t          pay_scalu;
  wb_payload_t          pay_lsq;
  wb_payload_t          pay_muldiv;
  logic [PAYLOAD_W-1:0] sel_bits;
  wb_payload_t          wb_q;
  logic                 wb_valid_q;
  logic [31:0]          conflicts_q;

  assign req = {muldiv_valid, lsq_valid, scalu_valid};

  assign pay_scalu  = '{error: scalu_error, ecause: scalu_ecause, robid: scalu_robid,
                        rd: scalu_rd, result: scalu_result};
  assign pay_lsq    = '{error: lsq_error, ecause: lsq_ecause, robid: lsq_robid,
                        rd: lsq_rd, result: lsq_result};
  assign pay_muldiv = '{error: muldiv_error, ecause: muldiv_ecause, robid: muldiv_robid,
                        rd: muldiv_rd, result: muldiv_result};

  // A flush suppresses arbitration entirely, so the pointer also holds
  rr_arb3 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (~rob_flush),
    .grant (grant)
  );

  // Producers drop their ops on a flush, so nobody is told to hold then.
  // Stalls depend only on inputs and arbiter state, never on wb_*.
  assign wb_scalu_stall  = scalu_valid  & ~grant[SRC_SCALU]  & ~rob_flush;
  assign wb_lsq_stall    = lsq_valid    & ~grant[SRC_LSQ]    & ~rob_flush;
  assign wb_muldiv_stall = muldiv_valid & ~grant[SRC_MULDIV] & ~rob_flush;

  // AND-OR mux of the payloads; the grant is one-hot or zero
  always_comb begin
    sel_bits = {PAYLOAD_W{1'b0}};
    sel_bits = sel_bits | ({PAYLOAD_W{grant[SRC_SCALU]}}  & pay_scalu);
    sel_bits = sel_bits | ({PAYLOAD_W{grant[SRC_LSQ]}}    & pay_lsq);
    sel_bits = sel_bits | ({PAYLOAD_W{grant[SRC_MULDIV]}} & pay_muldiv);
  end

  // Writeback register: valid follows the grant, data loads only on a grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      wb_valid_q <= |grant;
      if (|grant) begin
        wb_q <= wb_payload_t'(sel_bits);
      end
    end
  end

  // Saturating count of cycles where two or more producers compete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflicts_q <= CONFLICT_INIT;
    end else if ((popcount3(req) >= 2'd2) && !rob_flush && (conflicts_q != 32'hFFFF_FFFF)) begin
      conflicts_q <= conflicts_q + 32'd1;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_error     = wb_q.error;
  assign wb_ecause    = wb_q.ecause;
  assign wb_robid     = wb_q.robid;
  assign wb_rd        = wb_q.rd;
  assign wb_result    = wb_q.result;
  // Error ops and x0 destinations complete in the ROB without a regfile write
  assign wb_regwr     = wb_valid_q & ~wb_q.error & (wb_q.rd != '0);
  assign wb_conflicts = conflicts_q;

endmodule

// File: tb/tb_wbarb.sv
// tb/tb_wbarb.sv - randomized and directed self-checking bench for wbarb
module tb_wbarb;
  import wbarb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_sat;
  logic rob_flush;

  logic                v   [3];
  logic                er  [3];
  logic [ECAUSE_W-1:0] ec  [3];
  logic [ROBID_W-1:0]  rb  [3];
  logic [RD_W-1:0]     rdv [3];
  logic [XLEN-1:0]     rs  [3];

  logic                wb_scalu_stall, wb_lsq_stall, wb_muldiv_stall;
  logic                wb_valid, wb_error, wb_regwr;
  logic [ECAUSE_W-1:0] wb_ecause;
  logic [ROBID_W-1:0]  wb_robid;
  logic [RD_W-1:0]     wb_rd;
  logic [XLEN-1:0]     wb_result;
  logic [31:0]         wb_conflicts;

  logic                s_st0, s_st1, s_st2, s_valid, s_error, s_regwr;
  logic [ECAUSE_W-1:0] s_ecause;
  logic [ROBID_W-1:0]  s_robid;
  logic [RD_W-1:0]     s_rd;
  logic [XLEN-1:0]     s_result;
  logic [31:0]         s_conflicts;

  wbarb dut (
    .clk(clk), .rst(rst),
    .scalu_valid(v[0]), .scalu_error(er[0]), .scalu_ecause(ec[0]),
    .scalu_robid(rb[0]), .scalu_rd(rdv[0]), .scalu_result(rs[0]),
    .lsq_valid(v[1]), .lsq_error(er[1]), .lsq_ecause(ec[1]),
    .lsq_robid(rb[1]), .lsq_rd(rdv[1]), .lsq_result(rs[1]),
    .muldiv_valid(v[2]), .muldiv_error(er[2]), .muldiv_ecause(ec[2]),
    .muldiv_robid(rb[2]), .muldiv_rd(rdv[2]), .muldiv_result(rs[2]),
    .wb_scalu_stall(wb_scalu_stall), .wb_lsq_stall(wb_lsq_stall),
    .wb_muldiv_stall(wb_muldiv_stall),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_ecause(wb_ecause),
    .wb_robid(wb_robid), .wb_rd(wb_rd), .wb_result(wb_result),
    .wb_regwr(wb_regwr), .wb_conflicts(wb_conflicts),
    .rob_flush(rob_flush)
  );

  // Second instance starting near the counter ceiling, all producers busy
  wbarb #(.CONFLICT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst(rst_sat),
    .scalu_valid(1'b1), .scalu_error(1'b0), .scalu_ecause(5'd0),
    .scalu_robid(7'd1), .scalu_rd(6'd1), .scalu_result(32'd1),
    .lsq_valid(1'b1), .lsq_error(1'b0), .lsq_ecause(5'd0),
    .lsq_robid(7'd2), .lsq_rd(6'd2), .lsq_result(32'd2),
    .muldiv_valid(1'b1), .muldiv_error(1'b0), .muldiv_ecause(5'd0),
    .muldiv_robid(7'd3), .muldiv_rd(6'd3), .muldiv_result(32'd3),
    .wb_scalu_stall(s_st0), .wb_lsq_stall(s_st1), .wb_muldiv_stall(s_st2),
    .wb_valid(s_valid), .wb_error(s_error), .wb_ecause(s_ecause),
    .wb_robid(s_robid), .wb_rd(s_rd), .wb_result(s_result),
    .wb_regwr(s_regwr), .wb_conflicts(s_conflicts),
    .rob_flush(1'b0)
  );

  // Reference model state: what the writeback bus must hold
  int                  m_last;
  logic                m_valid, m_err;
  logic [ECAUSE_W-1:0] m_ec;
  logic [ROBID_W-1:0]  m_rob;
  logic [RD_W-1:0]     m_rd;
  logic [XLEN-1:0]     m_res;
  logic [31:0]         m_conf;
  logic [2:0]          exp_g;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scan requesters starting one past the last winner
  function automatic logic [2:0] mgrant(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (req[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_last = 2; m_valid = 0; m_err = 0; m_ec = '0; m_rob = '0; m_rd = '0; m_res = '0;
    m_conf = '0; exp_g = '0;
  endtask

  task automatic check_wb();
    chk("wb_valid", wb_valid, m_valid);
    chk("wb_error", wb_error, m_err);
    chk("wb_ecause", wb_ecause, m_ec);
    chk("wb_robid", wb_robid, m_rob);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_result", wb_result, m_res);
    chk("wb_regwr", wb_regwr, m_valid & ~m_err & (m_rd != 0));
    chk("wb_conflicts", wb_conflicts, m_conf);
  endtask

  // One clock: called at a negedge with inputs set; returns at the next negedge
  task automatic cycle();
    logic [2:0] req;
    int nreq;
    req   = {v[2], v[1], v[0]};
    nreq  = int'(v[0]) + int'(v[1]) + int'(v[2]);
    exp_g = rob_flush ? 3'b000 : mgrant(req, m_last);
    #1;
    chk("scalu_stall", wb_scalu_stall, v[0] & ~exp_g[0] & ~rob_flush);
    chk("lsq_stall", wb_lsq_stall, v[1] & ~exp_g[1] & ~rob_flush);
    chk("muldiv_stall", wb_muldiv_stall, v[2] & ~exp_g[2] & ~rob_flush);
    @(posedge clk);
    m_valid = (exp_g != 0);
    for (int i = 0; i < 3; i++) begin
      if (exp_g[i]) begin
        m_last = i; m_err = er[i]; m_ec = ec[i]; m_rob = rb[i]; m_rd = rdv[i]; m_res = rs[i];
      end
    end
    if (nreq >= 2 && !rob_flush && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
    #1;
    check_wb();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      v[i] = 0; er[i] = 0; ec[i] = '0; rb[i] = '0; rdv[i] = '0; rs[i] = '0;
    end
    rob_flush = 0;
  endtask

  task automatic set_src(input int i, input logic val, input logic e, input logic [4:0] c,
                         input logic [6:0] r, input logic [5:0] d, input logic [31:0] x);
    v[i] = val; er[i] = e; ec[i] = c; rb[i] = r; rdv[i] = d; rs[i] = x;
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst_sat = 0;
    clear_inputs();
    do_reset();
    // reset state
    check_wb();
    chk("reset_valid_lit", wb_valid, 1'b0);
    chk("reset_conf_lit", wb_conflicts, 32'd0);

    // only scalu, repeated
    set_src(0, 1, 0, 5'd0, 7'd5, 6'd3, 32'h1234);
    repeat (4) begin
      cycle();
      chk("t2_valid", wb_valid, 1'b1);
      chk("t2_regwr", wb_regwr, 1'b1);
      chk("t2_robid", wb_robid, 7'd5);
      chk("t2_result", wb_result, 32'h1234);
      chk("t2_stall", wb_scalu_stall, 1'b0);
    end

    // asynchronous reset while the bus is valid
    rst = 0;
    #1;
    model_reset();
    chk("t1_valid", wb_valid, 1'b0);
    chk("t1_regwr", wb_regwr, 1'b0);
    chk("t1_result", wb_result, 32'd0);
    chk("t1_robid", wb_robid, 7'd0);
    @(negedge clk);
    rst = 1;
    set_src(0, 1, 0, 5'd0, 7'd9, 6'd4, 32'hBEEF);
    cycle();
    chk("t1_after_valid", wb_valid, 1'b1);
    chk("t1_after_robid", wb_robid, 7'd9);

    // all three held from reset
    clear_inputs();
    do_reset();
    set_src(0, 1, 0, 5'd0, 7'd10, 6'd1, 32'hA0);
    set_src(1, 1, 0, 5'd0, 7'd11, 6'd2, 32'hA1);
    set_src(2, 1, 0, 5'd0, 7'd12, 6'd3, 32'hA2);
    #1;
    chk("t3_scalu_stall", wb_scalu_stall, 1'b0);
    chk("t3_lsq_stall", wb_lsq_stall, 1'b1);
    chk("t3_muldiv_stall", wb_muldiv_stall, 1'b1);
    cycle(); chk("t3_g1", wb_robid, 7'd10); chk("t3_c1", wb_conflicts, 32'd1);
    cycle(); chk("t3_g2", wb_robid, 7'd11); chk("t3_c2", wb_conflicts, 32'd2);
    cycle(); chk("t3_g3", wb_robid, 7'd12); chk("t3_c3", wb_conflicts, 32'd3);
    cycle(); chk("t3_g4", wb_robid, 7'd10); chk("t3_c4", wb_conflicts, 32'd4);

    // error op and rd==0 op
    clear_inputs();
    set_src(1, 1, 1, 5'd5, 7'd30, 6'd7, 32'hDEAD);
    cycle();
    chk("t4_error", wb_error, 1'b1);
    chk("t4_ecause", wb_ecause, 5'd5);
    chk("t4_regwr", wb_regwr, 1'b0);
    chk("t4_valid", wb_valid, 1'b1);
    clear_inputs();
    set_src(0, 1, 0, 5'd0, 7'd31, 6'd0, 32'h55);
    cycle();
    chk("t4_rd0_valid", wb_valid, 1'b1);
    chk("t4_rd0_regwr", wb_regwr, 1'b0);

    // flush with everyone requesting; last winner was scalu
    set_src(0, 1, 0, 5'd0, 7'd20, 6'd1, 32'hB0);
    set_src(1, 1, 0, 5'd0, 7'd21, 6'd2, 32'hB1);
    set_src(2, 1, 0, 5'd0, 7'd22, 6'd3, 32'hB2);
    rob_flush = 1;
    #1;
    chk("t5_stall_s", wb_scalu_stall, 1'b0);
    chk("t5_stall_l", wb_lsq_stall, 1'b0);
    chk("t5_stall_m", wb_muldiv_stall, 1'b0);
    cycle();
    chk("t5_valid", wb_valid, 1'b0);
    chk("t5_conf", wb_conflicts, 32'd4);
    rob_flush = 0;
    cycle();
    chk("t5_ptr_held", wb_robid, 7'd21);
    chk("t5_conf_after", wb_conflicts, 32'd5);

    // randomized traffic honouring the hold-on-stall rule
    clear_inputs();
    for (int n = 0; n < 600; n++) begin
      logic was_flush;
      was_flush = rob_flush;
      for (int i = 0; i < 3; i++) begin
        if (!(v[i] && !exp_g[i] && !was_flush)) begin
          v[i]   = ($urandom_range(0, 9) < 6);
          er[i]  = ($urandom_range(0, 7) == 0);
          ec[i]  = 5'($urandom);
          rb[i]  = 7'($urandom);
          rdv[i] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
          rs[i]  = $urandom;
        end
      end
      rob_flush = ($urandom_range(0, 11) == 0);
      cycle();
    end

    // saturation of the contention counter
    #1;
    chk("t6_init", s_conflicts, 32'hFFFF_FFFE);
    @(negedge clk);
    rst_sat = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("t6_sat", s_conflicts, 32'hFFFF_FFFF);
      chk("t6_valid", s_valid, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
